// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a registered four-phase req/ack handshake.
// Latency: write at edge N -> pop/send_req at N+1; backpressure: writes while full are dropped and flagged.
module uart_tx_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  input  logic                 clr_ovf,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 send_req,
  input  logic                 send_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 send_req_q, send_req_d;
  state_t               state_q, state_d;

  logic wr_accept;
  logic pop;

  // full/empty are the registered pre-edge view, so a pop cannot make room for a same-edge write.
  always_comb begin
    wr_accept  = wr_en && !full_q;
    pop        = (state_q == IDLE) && !empty_q;
    wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_accept && pop) begin
      count_d = count_q - CNT_ONE;
    end
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
    overflow_d = (wr_en && full_q) || (overflow_q && !clr_ovf);
  end

  always_comb begin
    state_d    = state_q;
    send_req_d = send_req_q;
    dout_d     = dout_q;
    unique case (state_q)
      IDLE: begin
        send_req_d = 1'b0;
        if (pop) begin
          dout_d     = mem_q[rd_ptr_q];
          send_req_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        send_req_d = 1'b1;
        if (send_ack) begin
          send_req_d = 1'b0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        send_req_d = 1'b0;
        if (!send_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        send_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      dout_q     <= '0;
      send_req_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
      send_req_q <= send_req_d;
      state_q    <= state_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dout     = dout_q;
  assign send_req = send_req_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed handshake/overflow/reset scenarios plus randomized bursts
// checked against an in-order byte queue and a randomly delayed transmitter model.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_ovf;
  logic [DW-1:0] dout;
  logic          send_req;
  logic          send_ack;

  int n_checks;
  int n_errors;
  int tx_delay;
  bit xmit_en;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] exp_q[$];

  uart_tx_feeder #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf), .dout(dout), .send_req(send_req), .send_ack(send_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; when enabled, act as the transmitter: ack after a random delay, drop ack once req falls.
  task automatic tick();
    @(negedge clk);
    if (xmit_en) begin
      if (send_req && !send_ack) begin
        if (tx_delay == 0) begin
          rx_q.push_back(dout);
          send_ack = 1'b1;
          tx_delay = $urandom_range(0, 3);
        end else begin
          tx_delay--;
        end
      end else if (!send_req && send_ack) begin
        send_ack = 1'b0;
      end
    end
  endtask

  task automatic wr(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int n, input string tag);
    int budget;
    budget = 2000;
    while (!(rx_q.size() >= n && !send_req && !send_ack && empty) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: received %0d bytes, required %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic compare_stream(input string tag);
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL %s_len: got %0d bytes, expected %0d", tag, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL %s_byte%0d: got %h, expected %h", tag, i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0; send_ack = 1'b0; xmit_en = 1'b0;
    tick(); tick();
    n_checks++; if (send_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b, expected 0", send_req); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL reset_flags: empty=%b full=%b, expected 1/0", empty, full); end
    n_checks++; if (overflow !== 1'b0 || dout !== 8'h00) begin n_errors++; $display("FAIL reset_ovf_dout: ovf=%b dout=%h, expected 0/00", overflow, dout); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr(8'hA5);
    n_checks++; if (count !== 5'd1 || send_req !== 1'b0) begin n_errors++; $display("FAIL single_write: count=%0d req=%b, expected 1/0", count, send_req); end
    tick();
    n_checks++; if (send_req !== 1'b1 || dout !== 8'hA5) begin n_errors++; $display("FAIL single_pop: req=%b dout=%h, expected 1/a5", send_req, dout); end
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_errors++; $display("FAIL single_count: count=%0d empty=%b, expected 0/1", count, empty); end
    tick(); tick();
    n_checks++; if (send_req !== 1'b1 || dout !== 8'hA5) begin n_errors++; $display("FAIL single_hold: req=%b dout=%h, expected 1/a5", send_req, dout); end
    send_ack = 1'b1;
    tick();
    n_checks++; if (send_req !== 1'b0) begin n_errors++; $display("FAIL single_release: req=%b, expected 0", send_req); end
  endtask

  task automatic test_four_phase();
    // ack still high from the single-byte handshake: queue a byte and keep ack high for 5 cycles.
    wr(8'h3C);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (send_req !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL fourphase_hold%0d: req=%b count=%0d, expected 0/1", i, send_req, count); end
      tick();
    end
    send_ack = 1'b0;
    tick();
    n_checks++; if (send_req !== 1'b0) begin n_errors++; $display("FAIL fourphase_idle: req=%b, expected 0", send_req); end
    tick();
    n_checks++; if (send_req !== 1'b1 || dout !== 8'h3C) begin n_errors++; $display("FAIL fourphase_next: req=%b dout=%h, expected 1/3c", send_req, dout); end
    send_ack = 1'b1; tick(); tick();
    send_ack = 1'b0; tick();
    // ack high in IDLE with an empty FIFO must not start anything; a late byte is sent and released at once.
    send_ack = 1'b1; tick(); tick();
    n_checks++; if (send_req !== 1'b0) begin n_errors++; $display("FAIL idle_ack_ignored: req=%b, expected 0", send_req); end
    wr(8'h5A);
    tick();
    n_checks++; if (send_req !== 1'b1 || dout !== 8'h5A) begin n_errors++; $display("FAIL idle_ack_pop: req=%b dout=%h, expected 1/5a", send_req, dout); end
    tick();
    n_checks++; if (send_req !== 1'b0) begin n_errors++; $display("FAIL idle_ack_exit: req=%b, expected 0", send_req); end
    send_ack = 1'b0; tick(); tick();
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) begin
      wr(DW'(i));
      exp_q.push_back(DW'(i));
    end
    // 16 accepted, one already popped into dout while the transmitter stalls.
    n_checks++; if (count !== 5'd15 || full !== 1'b0) begin n_errors++; $display("FAIL burst_count: count=%0d full=%b, expected 15/0", count, full); end
    n_checks++; if (overflow !== 1'b0 || send_req !== 1'b1 || dout !== 8'h00) begin n_errors++; $display("FAIL burst_head: ovf=%b req=%b dout=%h, expected 0/1/00", overflow, send_req, dout); end
    xmit_en = 1'b1;
    wait_drain(16, "burst");
    xmit_en = 1'b0;
    compare_stream("burst");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) wr(8'h40 + DW'(i));
    n_checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_fill: count=%0d full=%b ovf=%b, expected 16/1/0", count, full, overflow); end
    n_checks++; if (send_req !== 1'b1 || dout !== 8'h40) begin n_errors++; $display("FAIL ovf_head: req=%b dout=%h, expected 1/40", send_req, dout); end
    wr(8'hFF);
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin n_errors++; $display("FAIL ovf_drop: ovf=%b count=%0d, expected 1/16", overflow, count); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: ovf=%b, expected 0", overflow); end
    clr_ovf = 1'b1; wr(8'hFE); clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: ovf=%b, expected 1", overflow); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    // Complete byte 0's handshake so the next edge pops, and write on that same edge.
    send_ack = 1'b1; tick();
    send_ack = 1'b0; tick();
    wr(8'hEE);
    n_checks++; if (count !== 5'd15 || full !== 1'b0 || overflow !== 1'b1) begin n_errors++; $display("FAIL fullpop: count=%0d full=%b ovf=%b, expected 15/0/1", count, full, overflow); end
    n_checks++; if (send_req !== 1'b1 || dout !== 8'h41) begin n_errors++; $display("FAIL fullpop_head: req=%b dout=%h, expected 1/41", send_req, dout); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    for (int i = 1; i < 17; i++) exp_q.push_back(8'h40 + DW'(i));
    xmit_en = 1'b1;
    wait_drain(16, "ovf_drain");
    xmit_en = 1'b0;
    compare_stream("ovf_drain");
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_after_drain: ovf=%b, expected 0", overflow); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      xmit_en = 1'b1;
      for (int i = 0; i < n; i++) begin
        logic [DW-1:0] b;
        b = DW'($urandom);
        wr(b);
        exp_q.push_back(b);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain(n, "random");
      xmit_en = 1'b0;
      compare_stream("random");
      n_checks++; if (overflow !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL random_end%0d: ovf=%b count=%0d, expected 0/0", r, overflow, count); end
    end
  endtask

  task automatic test_reset_mid_req();
    for (int i = 0; i < 4; i++) wr(8'h90 + DW'(i));
    n_checks++; if (send_req !== 1'b1 || count !== 5'd3) begin n_errors++; $display("FAIL midreq_setup: req=%b count=%0d, expected 1/3", send_req, count); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (send_req !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin n_errors++; $display("FAIL midreq_reset: req=%b count=%0d empty=%b, expected 0/0/1", send_req, count, empty); end
    n_checks++; if (dout !== 8'h00 || full !== 1'b0) begin n_errors++; $display("FAIL midreq_dout: dout=%h full=%b, expected 00/0", dout, full); end
    reset_n = 1'b1;
    tick();
    wr(8'h77);
    exp_q.push_back(8'h77);
    xmit_en = 1'b1;
    wait_drain(1, "post_reset");
    xmit_en = 1'b0;
    compare_stream("post_reset");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tx_delay = 0;
    test_reset();
    test_single();
    test_four_phase();
    test_burst();
    test_overflow();
    test_random();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
